// File: rtl/fft_bank_wr_ctrl.sv
// Write-side controller for the radix-4 in-place FFT memory: mixer rotation select plus
// registered per-bank write addresses. Define FFT_WR_DIT_EN for DIT digit ordering (default DIF).
module fft_bank_wr_ctrl #(
  parameter  int unsigned N_LOG2  = 8,
  localparam int unsigned ADDR_W  = N_LOG2 - 2,
  localparam int unsigned S       = N_LOG2 / 2,
  localparam int unsigned STAGE_W = (S > 1) ? $clog2(S) : 1
) (
  input  logic               iCLK,
  input  logic               iRESET,
  input  logic               iSTART,
  input  logic               iVALID,
  output logic [1:0]         oSEL,
  output logic               oWE,
  output logic [ADDR_W-1:0]  oADDR0,
  output logic [ADDR_W-1:0]  oADDR1,
  output logic [ADDR_W-1:0]  oADDR2,
  output logic [ADDR_W-1:0]  oADDR3,
  output logic [STAGE_W-1:0] oSTAGE,
  output logic               oBUSY,
  output logic               oDONE
);

  typedef enum logic [1:0] {IDLE, RUN, LAST} state_e;

  state_e              state_q, state_d;
  logic [STAGE_W-1:0]  s_q, s_d;
  logic [ADDR_W-1:0]   b_q, b_d;
  logic                we_q, we_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic [ADDR_W-1:0]   addr_q [4];
  logic [ADDR_W-1:0]   addr_d [4];
  logic [ADDR_W-1:0]   addr_c [4];
  logic [1:0]          base_c;
  logic [STAGE_W-1:0]  p_c;
  logic                last_c;

  // Insert base-4 digit k into b at digit position p, then drop the bank-select digit.
  function automatic logic [ADDR_W-1:0] bank_addr(input logic [ADDR_W-1:0] b,
                                                  input logic [1:0] k,
                                                  input logic [STAGE_W-1:0] p);
    logic [N_LOG2-1:0] bw;
    logic [N_LOG2-1:0] kw;
    logic [N_LOG2-1:0] lo_mask;
    logic [N_LOG2-1:0] n;
    logic [STAGE_W:0]  sh;
    sh      = {p, 1'b0};
    bw      = N_LOG2'(b);
    kw      = N_LOG2'(k);
    lo_mask = ~({N_LOG2{1'b1}} << sh);
    n       = (((bw >> sh) << 2) << sh) | (kw << sh) | (bw & lo_mask);
    return ADDR_W'(n >> 2);
  endfunction

`ifdef FFT_WR_DIT_EN
  assign p_c = s_q;
`else
  assign p_c = STAGE_W'(S - 1) - s_q;
`endif

  // Rotation base is the base-4 digit sum of the butterfly index, mod 4.
  always_comb begin
    base_c = 2'b00;
    for (int unsigned i = 0; i < S - 1; i++) begin
      base_c = base_c + b_q[2*i +: 2];
    end
  end

  always_comb begin
    for (int unsigned j = 0; j < 4; j++) begin
      addr_c[j] = bank_addr(b_q, 2'(j) - base_c, p_c);
    end
  end

  assign last_c = (s_q == STAGE_W'(S - 1)) && (&b_q);

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q <= IDLE;
      s_q     <= '0;
      b_q     <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      addr_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      b_q     <= b_d;
      we_q    <= we_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    b_d     = b_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (iSTART) begin
          state_d = RUN;
          s_d     = '0;
          b_d     = '0;
        end
      end
      RUN: begin
        if (iVALID) begin
          we_d   = 1'b1;
          addr_d = addr_c;
          b_d    = b_q + 1'b1;
          if (last_c) begin
            done_d  = 1'b1;
            state_d = LAST;
          end else if (&b_q) begin
            s_d = s_q + 1'b1;
          end
        end
      end
      LAST:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign oSEL   = base_c;
  assign oWE    = we_q;
  assign oADDR0 = addr_q[0];
  assign oADDR1 = addr_q[1];
  assign oADDR2 = addr_q[2];
  assign oADDR3 = addr_q[3];
  assign oSTAGE = s_q;
  assign oBUSY  = busy_q;
  assign oDONE  = done_q;

endmodule

// File: tb/tb_fft_bank_wr_ctrl.sv
// Bench for fft_bank_wr_ctrl: N=16 vector table plus randomized N=256 runs against a digit-level model.
module tb_fft_bank_wr_ctrl;

`ifdef FFT_WR_DIT_EN
  localparam bit DIT = 1'b1;
`else
  localparam bit DIT = 1'b0;
`endif
  localparam int S8  = 4;
  localparam int NB8 = 64;

  typedef struct {
    int s; int b; int sel; int a0; int a1; int a2; int a3; bit done;
  } vec_t;

  logic       clk;
  logic       rst4, start4, valid4, we4, busy4, done4;
  logic [1:0] sel4;
  logic [1:0] a4 [4];
  logic [0:0] stage4;
  logic       rst8, start8, valid8, we8, busy8, done8;
  logic [1:0] sel8;
  logic [5:0] a8 [4];
  logic [1:0] stage8;

  int n_vec = 0;
  int n_err = 0;
  vec_t tbl [8];

  int ms8, mb8, wecnt8, dups8;
  bit fin8;
  bit seen8 [4][64];

  fft_bank_wr_ctrl #(.N_LOG2(4)) u_dut4 (
    .iCLK(clk), .iRESET(rst4), .iSTART(start4), .iVALID(valid4), .oSEL(sel4), .oWE(we4),
    .oADDR0(a4[0]), .oADDR1(a4[1]), .oADDR2(a4[2]), .oADDR3(a4[3]),
    .oSTAGE(stage4), .oBUSY(busy4), .oDONE(done4)
  );

  fft_bank_wr_ctrl #(.N_LOG2(8)) u_dut8 (
    .iCLK(clk), .iRESET(rst8), .iSTART(start8), .iVALID(valid8), .oSEL(sel8), .oWE(we8),
    .oADDR0(a8[0]), .oADDR1(a8[1]), .oADDR2(a8[2]), .oADDR3(a8[3]),
    .oSTAGE(stage8), .oBUSY(busy8), .oDONE(done8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int dsum(input int x);
    int acc = 0;
    int v = x;
    while (v > 0) begin
      acc += v % 4;
      v = v / 4;
    end
    return acc;
  endfunction

  // Point index: butterfly b with digit k placed at base-4 position p.
  function automatic int pt(input int b, input int k, input int p);
    int w = 1 << (2 * p);
    return (b / w) * w * 4 + k * w + b % w;
  endfunction

  task automatic model_reset8();
    ms8 = 0; mb8 = 0; dups8 = 0; fin8 = 1'b0;
    foreach (seen8[i, j]) seen8[i][j] = 1'b0;
  endtask

  // One N=256 cycle: drive iVALID, check select now and the registered write next cycle.
  task automatic cycle8(input bit v);
    int ea [4];
    int p, n;
    bit last;
    last = 1'b0;
    valid8 = v;
    if (v) begin
      check("sel8", int'(sel8), dsum(mb8) % 4);
      check("stage8", int'(stage8), ms8);
      p = DIT ? ms8 : S8 - 1 - ms8;
      for (int k = 0; k < 4; k++) begin
        n = pt(mb8, k, p);
        ea[dsum(n) % 4] = n / 4;
      end
      last = (ms8 == S8 - 1) && (mb8 == NB8 - 1);
    end
    step();
    check("we8", int'(we8), int'(v));
    check("busy8", int'(busy8), 1);
    check("done8", int'(done8), int'(last));
    if (v) begin
      wecnt8++;
      for (int j = 0; j < 4; j++) begin
        check($sformatf("addr8_%0d", j), int'(a8[j]), ea[j]);
        if (seen8[j][ea[j]]) dups8++;
        seen8[j][ea[j]] = 1'b1;
      end
      mb8++;
      if (mb8 == NB8) begin
        check("stage_dups8", dups8, 0);
        dups8 = 0;
        foreach (seen8[i, j]) seen8[i][j] = 1'b0;
        mb8 = 0;
        if (last) fin8 = 1'b1;
        else ms8++;
      end
    end
  endtask

  initial begin
`ifdef FFT_WR_DIT_EN
    tbl[0] = '{0, 0, 0, 0, 0, 0, 0, 1'b0};
    tbl[1] = '{0, 1, 1, 1, 1, 1, 1, 1'b0};
    tbl[2] = '{0, 2, 2, 2, 2, 2, 2, 1'b0};
    tbl[3] = '{0, 3, 3, 3, 3, 3, 3, 1'b0};
    tbl[4] = '{1, 0, 0, 0, 1, 2, 3, 1'b0};
    tbl[5] = '{1, 1, 1, 3, 0, 1, 2, 1'b0};
    tbl[6] = '{1, 2, 2, 2, 3, 0, 1, 1'b0};
    tbl[7] = '{1, 3, 3, 1, 2, 3, 0, 1'b1};
`else
    tbl[0] = '{0, 0, 0, 0, 1, 2, 3, 1'b0};
    tbl[1] = '{0, 1, 1, 3, 0, 1, 2, 1'b0};
    tbl[2] = '{0, 2, 2, 2, 3, 0, 1, 1'b0};
    tbl[3] = '{0, 3, 3, 1, 2, 3, 0, 1'b0};
    tbl[4] = '{1, 0, 0, 0, 0, 0, 0, 1'b0};
    tbl[5] = '{1, 1, 1, 1, 1, 1, 1, 1'b0};
    tbl[6] = '{1, 2, 2, 2, 2, 2, 2, 1'b0};
    tbl[7] = '{1, 3, 3, 3, 3, 3, 3, 1'b1};
`endif
    wecnt8 = 0;
    model_reset8();
    rst4 = 1'b1; start4 = 1'b0; valid4 = 1'b1;
    rst8 = 1'b1; start8 = 1'b0; valid8 = 1'b0;
    step();
    step();
    check("rst_we4", int'(we4), 0);
    check("rst_busy4", int'(busy4), 0);
    check("rst_done4", int'(done4), 0);
    check("rst_stage4", int'(stage4), 0);
    for (int j = 0; j < 4; j++) check($sformatf("rst_addr4_%0d", j), int'(a4[j]), 0);
    check("rst_we8", int'(we8), 0);
    check("rst_busy8", int'(busy8), 0);
    check("rst_stage8", int'(stage8), 0);

    // iVALID while idle must not write or move the counters
    rst4 = 1'b0; rst8 = 1'b0;
    step();
    check("idle_we4", int'(we4), 0);
    check("idle_busy4", int'(busy4), 0);
    check("idle_stage4", int'(stage4), 0);

    valid4 = 1'b0; start4 = 1'b1;
    step();
    start4 = 1'b0;
    check("start_busy4", int'(busy4), 1);

    for (int i = 0; i < 8; i++) begin
      valid4 = 1'b1;
      check($sformatf("sel4_v%0d", i), int'(sel4), tbl[i].sel);
      check($sformatf("stage4_v%0d", i), int'(stage4), tbl[i].s);
      step();
      check($sformatf("we4_v%0d", i), int'(we4), 1);
      check($sformatf("a0_v%0d", i), int'(a4[0]), tbl[i].a0);
      check($sformatf("a1_v%0d", i), int'(a4[1]), tbl[i].a1);
      check($sformatf("a2_v%0d", i), int'(a4[2]), tbl[i].a2);
      check($sformatf("a3_v%0d", i), int'(a4[3]), tbl[i].a3);
      check($sformatf("done4_v%0d", i), int'(done4), int'(tbl[i].done));
      check($sformatf("busy4_v%0d", i), int'(busy4), 1);
    end

    // iSTART in LAST is ignored; the one at t+2 is accepted
    valid4 = 1'b0; start4 = 1'b1;
    step();
    check("t2_busy4", int'(busy4), 0);
    check("t2_we4", int'(we4), 0);
    check("t2_done4", int'(done4), 0);
    step();
    start4 = 1'b0;
    check("restart_busy4", int'(busy4), 1);
    valid4 = 1'b1;
    check("restart_sel4", int'(sel4), tbl[0].sel);
    check("restart_stage4", int'(stage4), 0);
    step();
    valid4 = 1'b0;
    check("restart_a0_4", int'(a4[0]), tbl[0].a0);
    check("restart_a3_4", int'(a4[3]), tbl[0].a3);

    // Randomized gapped run on N=256, with stray iSTART pulses mid-run
    model_reset8();
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    for (int c = 0; c < 4000 && !fin8; c++) begin
      start8 = ($urandom_range(0, 7) == 0);
      cycle8($urandom_range(0, 2) != 0);
    end
    if (!fin8) check("timeout8", 0, 1);
    check("we_total8", wecnt8, 256);
    start8 = 1'b0; valid8 = 1'b0;
    step();
    check("end_busy8", int'(busy8), 0);
    check("end_we8", int'(we8), 0);

    // Reset after 37 butterflies abandons the run
    model_reset8();
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    for (int i = 0; i < 37; i++) cycle8(1'b1);
    rst8 = 1'b1; valid8 = 1'b1;
    step();
    rst8 = 1'b0; valid8 = 1'b0;
    check("midrst_we8", int'(we8), 0);
    check("midrst_busy8", int'(busy8), 0);
    check("midrst_done8", int'(done8), 0);
    check("midrst_stage8", int'(stage8), 0);
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    model_reset8();
    cycle8(1'b1);
    cycle8(1'b1);
    cycle8(1'b0);
    valid8 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
